// File: rtl/mos_req_sched.sv
// mos_req_sched: round-robin scheduler that shares one MOS switch controller
// among NREQ requesters. Each grant runs a single transaction: mos_val is
// latched at grant, mos_req is raised, the first mos_ack after a blanking
// window completes it, and an optional watchdog ends it if no ack arrives.
//
// Ports
//   clk, rst     clock; asynchronous active-high reset
//   req_vec      per-requester request level, held until its done/err pulse
//   val_vec      per-requester requested MOS state, sampled at grant
//   done_vec     one-cycle pulse: requester i's transaction acknowledged
//   err_vec      one-cycle pulse: requester i's transaction timed out
//   mos_req      request level to the MOS controller
//   mos_val      MOS state to the controller, stable for the transaction
//   mos_ack      ack pulse from the MOS controller
//   reg_timeout  watchdog limit in WAIT_ACK cycles; 0 disables the watchdog
//   busy         high whenever the scheduler is not idle
//   grant_id     index of the current/last granted requester
module mos_req_sched #(
  parameter int NREQ  = 4,
  parameter int BLANK = 4,
  parameter int GAP   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_vec,
  input  logic [NREQ-1:0] val_vec,
  output logic [NREQ-1:0] done_vec,
  output logic [NREQ-1:0] err_vec,
  output logic            mos_req,
  output logic            mos_val,
  input  logic            mos_ack,
  input  logic [15:0]     reg_timeout,
  output logic            busy,
  output logic [2:0]      grant_id
);

  localparam int unsigned NR = NREQ;
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CMAX = (BLANK > GAP) ? BLANK : GAP;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_GAP
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt;
  logic [15:0]     wd;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   g_q;
  logic [IW-1:0]   pick;
  logic            found;
  logic            to_hit;
  int unsigned     idx;

  assign busy     = (state != ST_IDLE);
  assign grant_id = 3'(g_q);

  // First requesting index at or after ptr, scanning cyclically.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NR; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NR) idx = idx - NR;
      if (!found && req_vec[IW'(idx)]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  // Ack takes priority over an expiring watchdog in the same cycle.
  assign to_hit = (state == ST_WAIT) && !mos_ack && (reg_timeout != '0) &&
                  (wd >= reg_timeout - 16'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // REQ lasts BLANK+1 cycles: the first cycle registers mos_req, the next
  // BLANK cycles are the blanking window with mos_req already high.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (found)                   state_n = ST_REQ;
      ST_REQ:  if (cnt == CW'(BLANK))       state_n = ST_WAIT;
      ST_WAIT: if (mos_ack || to_hit)       state_n = ST_GAP;
      ST_GAP:  if (cnt == CW'(GAP - 1))     state_n = ST_IDLE;
      default:                              state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      wd       <= '0;
      ptr      <= '0;
      g_q      <= '0;
      mos_val  <= 1'b0;
      mos_req  <= 1'b0;
      done_vec <= '0;
      err_vec  <= '0;
    end else begin
      done_vec <= '0;
      err_vec  <= '0;

      // mos_req follows the FSM one cycle behind grant and drops on the
      // same edge that issues the done/err pulse.
      mos_req <= ((state == ST_REQ) && (state_n == ST_REQ)) || (state_n == ST_WAIT);

      if (state_n != state)                         cnt <= '0;
      else if (state == ST_REQ || state == ST_GAP)  cnt <= cnt + 1'b1;

      // Held at zero outside WAIT_ACK, so it starts cleared on entry.
      if (state != ST_WAIT)  wd <= '0;
      else if (wd != '1)     wd <= wd + 16'd1;

      if (state == ST_IDLE && found) begin
        g_q     <= pick;
        mos_val <= val_vec[pick];
      end

      if (state == ST_WAIT && mos_ack) done_vec <= NREQ'(1'b1) << g_q;
      else if (to_hit)                 err_vec  <= NREQ'(1'b1) << g_q;

      if (state == ST_GAP && state_n == ST_IDLE)
        ptr <= (g_q == IW'(NREQ - 1)) ? '0 : g_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_mos_req_sched.sv
module tb_mos_req_sched;

  localparam int NREQ  = 4;
  localparam int BLANK = 4;
  localparam int GAP   = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req_vec;
  logic [NREQ-1:0] val_vec;
  logic [NREQ-1:0] done_vec;
  logic [NREQ-1:0] err_vec;
  logic            mos_req;
  logic            mos_val;
  logic            mos_ack;
  logic [15:0]     reg_timeout;
  logic            busy;
  logic [2:0]      grant_id;

  int checks   = 0;
  int failures = 0;
  int ptr_m    = 0;

  mos_req_sched #(.NREQ(NREQ), .BLANK(BLANK), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .req_vec(req_vec), .val_vec(val_vec),
    .done_vec(done_vec), .err_vec(err_vec), .mos_req(mos_req),
    .mos_val(mos_val), .mos_ack(mos_ack), .reg_timeout(reg_timeout),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round-robin reference: first set request at or after p, cyclically.
  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (p + k) % NREQ;
      if (r[i]) return i;
    end
    return 0;
  endfunction

  // One transaction, entered with the DUT idle and req_vec already set.
  // d    : edge (counted from the mos_req rise edge) at which ack is sampled;
  //        0 = never ack. A spurious ack is also injected inside the blank window.
  // hold : ack held high from mos_req rise instead of a pulse.
  task automatic run_txn(input int d, input bit hold, input bit drop, input bit keep);
    int   g, waited, eff, end_k;
    bit   will_done;
    logic ev;
    logic [31:0] exp_pulse;
    g  = rr_pick(req_vec, ptr_m);
    ev = val_vec[g];
    waited = 0;
    while (mos_req !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    chk("req_to_mos_req_latency", waited, 2);
    chk("grant_id", 32'(grant_id), g);
    chk("mos_val_at_grant", 32'(mos_val), 32'(ev));
    val_vec = NREQ'($urandom);
    if (drop) req_vec[g] = 1'b0;
    eff       = hold ? BLANK + 1 : d;
    will_done = (hold || d > 0) &&
                (reg_timeout == 16'd0 || eff <= BLANK + int'(reg_timeout));
    end_k     = will_done ? eff : BLANK + int'(reg_timeout);
    for (int k = 1; k <= end_k; k++) begin
      mos_ack = hold ? 1'b1 : (k == d || k == 2);
      @(negedge clk);
      exp_pulse = 32'(1) << g;
      chk("done_vec", 32'(done_vec), (k == end_k && will_done)  ? exp_pulse : 32'd0);
      chk("err_vec",  32'(err_vec),  (k == end_k && !will_done) ? exp_pulse : 32'd0);
      chk("mos_req_level", 32'(mos_req), (k < end_k) ? 32'd1 : 32'd0);
      if (k == 1 || k == end_k) chk("mos_val_stable", 32'(mos_val), 32'(ev));
    end
    mos_ack = 1'b0;
    if (!keep) req_vec[g] = 1'b0;
    ptr_m = (g + 1) % NREQ;
    for (int k = 1; k <= GAP; k++) begin
      @(negedge clk);
      chk("gap_mos_req", 32'(mos_req), 0);
      chk("gap_pulses", 32'(done_vec | err_vec), 0);
      chk("gap_busy", 32'(busy), (k < GAP) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    int waited, bad, g;
    rst = 1'b1;
    req_vec = '0;
    val_vec = '0;
    mos_ack = 1'b0;
    reg_timeout = 16'd100;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mos_req", 32'(mos_req), 0);
    chk("rst_mos_val", 32'(mos_val), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_done", 32'(done_vec), 0);
    chk("rst_err", 32'(err_vec), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single requester, ack 6 edges after mos_req rise.
    val_vec = 4'b0001;
    req_vec = 4'b0001;
    run_txn(6, 1'b0, 1'b0, 1'b0);

    // All requesting, each re-asserting immediately.
    req_vec = 4'b1111;
    for (int i = 0; i < 5; i++)
      run_txn(int'($urandom_range(BLANK + 10, BLANK + 1)), 1'b0, 1'b0, 1'b1);

    // Random request patterns, ack timing, drops and re-assertions.
    for (int i = 0; i < 12; i++) begin
      req_vec = req_vec | NREQ'($urandom);
      if (req_vec == '0) req_vec = 4'b0100;
      run_txn(int'($urandom_range(BLANK + 12, BLANK + 1)),
              ($urandom_range(3, 0) == 0), ($urandom_range(1, 0) == 1),
              ($urandom_range(1, 0) == 1));
    end

    // Watchdog expiry with no ack.
    reg_timeout = 16'd20;
    req_vec = req_vec | 4'b0010;
    run_txn(0, 1'b0, 1'b0, 1'b0);

    // Ack held from rise: accepted only after the blank window.
    reg_timeout = 16'd100;
    req_vec = req_vec | 4'b1000;
    run_txn(0, 1'b1, 1'b0, 1'b0);

    // Ack and watchdog in the same cycle, then ack one cycle too late.
    reg_timeout = 16'd5;
    req_vec = req_vec | 4'b0001;
    run_txn(BLANK + 5, 1'b0, 1'b0, 1'b0);
    req_vec = req_vec | 4'b0100;
    run_txn(BLANK + 6, 1'b0, 1'b0, 1'b0);

    // Watchdog disabled: stays waiting past the 16-bit counter range.
    reg_timeout = 16'd0;
    req_vec = 4'b1111;
    g = rr_pick(req_vec, ptr_m);
    waited = 0;
    while (mos_req !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    chk("wd_off_latency", waited, 2);
    chk("wd_off_grant", 32'(grant_id), g);
    bad = 0;
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk);
      if (err_vec !== '0 || done_vec !== '0 || mos_req !== 1'b1 || busy !== 1'b1) bad++;
    end
    chk("wd_off_no_err", bad, 0);

    // Asynchronous reset while waiting for ack.
    #2 rst = 1'b1;
    #1;
    chk("async_rst_mos_req", 32'(mos_req), 0);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_pulses", 32'(done_vec | err_vec), 0);
    @(negedge clk);
    chk("async_rst_grant_id", 32'(grant_id), 0);
    rst = 1'b0;
    ptr_m = 0;
    reg_timeout = 16'd100;
    run_txn(BLANK + 2, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
